sync_ram: RTL and testbench
===========================

// Module: sync_ram
// PURPOSE
//   Single-port synchronous RAM with a registered read port. It is the general data/program store of the CPU datapath.
//   One address bus is shared by reads and writes. A write enable selects a write each cycle.
//   Read data appears on dout one clock after the address is presented.
// PARAMETERS
//   addr_width  8  address bits; depth = 2**addr_width words
//   data_width  8  bits per word (din, dout, memory array)
// PORTS
//   clk    in   1           clock; all state changes on rising edge
//   rst_n  in   1           synchronous active-low reset
//   addr   in   addr_width  word address for read and write
//   din    in   data_width  write data
//   we     in   1           write enable (1 = write din to mem[addr])
//   dout   out  data_width  registered read data
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-low (ports clk, rst_n).
//   - Reset: on a rising clk edge with rst_n=0, dout <= 0.
//     The memory array is NOT cleared; its contents are retained across reset.
//     Writes are ignored while rst_n=0.
//   - Write: on a rising edge with rst_n=1 and we=1, mem[addr] <= din.
//   - Read: on every rising edge with rst_n=1, dout <= mem[addr].
//     Read latency is 1 cycle: change addr before edge N, and dout holds that word after edge N.
//   - Read-during-write, same edge and same address: write-first.
//     dout <= din, and mem[addr] is updated on that same edge.
//   - With we=0, din is don't-care. Memory is unchanged, and dout still tracks mem[addr] with 1-cycle latency.
//   - dout holds its value between edges. There are no combinational paths from inputs to dout.
//   - Addressing: full range 0 .. 2**addr_width-1. There is no wrap or out-of-range case, since addr is exactly addr_width bits.
//   - Power-up memory contents are undefined (X in simulation). The bench must write a word before checking it.
//   - No handshake, no busy/ready. One access per cycle, sustained back-to-back.
// STRUCTURE
//   - Single module, no sub-modules.
//   - Storage: reg [data_width-1:0] mem [0:2**addr_width-1]. Coded so synthesis infers block RAM with an output register.
//   - No shared package needed. Widths come from parameters only.
// TESTING
//   1. Write/read: we=1, addr=3, din=11 for 2 edges -> dout=11.
//      Then addr=6, din=22 for 2 edges -> dout=22.
//   2. Read-only: we=0, addr=3, din=33 for 2 edges -> dout=11 (mem[3] unchanged).
//      Then addr=6, din=44 -> dout=22.
//   3. Burst: we=1, write addr i, din=i*10 for i=1..9 on consecutive edges.
//      Then we=0, addr=i for one edge each -> dout=i*10 one cycle after each addr (10,20,...,90).
//   4. Write-first: we=1, addr=5, din=0xA5 -> dout=0xA5 after that same edge.
//      Then we=0 -> dout stays 0xA5.
//   5. Reset: with mem[3]=11 and dout nonzero, drive rst_n=0 for 1 edge -> dout=0.
//      During that reset edge drive we=1, addr=3, din=0xFF (write ignored).
//      Release rst_n, we=0, addr=3 -> dout=11.
//   6. Boundaries: write 0x5A at addr=0 and 0xC3 at addr=255 -> read back 0x5A and 0xC3.
//      Neighbours addr=1 and addr=254 are unaffected.

Source files
------------

// File: rtl/sync_ram_pkg.sv
// Shared defaults for the CPU data/program store.
package sync_ram_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 8;
   localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with a registered, write-first read port.
// Contents survive reset; only the output register is cleared.
module sync_ram
   import sync_ram_pkg::*;
#(
   parameter int addr_width = DEFAULT_ADDR_WIDTH,
   parameter int data_width = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [addr_width-1:0] addr,
   input  logic [data_width-1:0] din,
   input  logic                  we,
   output logic [data_width-1:0] dout
);

   localparam int DEPTH = 1 << addr_width;

   logic [data_width-1:0] mem [0:DEPTH-1];

   // Array kept in its own reset-free block so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (rst_n && we) begin
         mem[addr] <= din;
      end
   end

   // Output register; a same-address write forwards the new word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (we) begin
         dout <= din;
      end else begin
         dout <= mem[addr];
      end
   end

endmodule

// File: tb/tb_sync_ram.sv
// Self-checking bench for sync_ram against a word-array reference model.
module tb_sync_ram;

   logic       clk;
   logic       rst_n;
   logic [7:0] addr;
   logic [7:0] din;
   logic       we;
   logic [7:0] dout;

   logic [7:0] ref_mem [256];
   bit         ref_valid [256];
   logic [7:0] exp_dout;

   int checks;
   int errors;

   sync_ram #(
      .addr_width(8),
      .data_width(8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .addr (addr),
      .din  (din),
      .we   (we),
      .dout (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock of stimulus; the model applies the documented edge rules.
   task automatic drive_edge(input logic r, input logic w, input logic [7:0] a,
                             input logic [7:0] d);
      @(negedge clk);
      rst_n = r;
      we    = w;
      addr  = a;
      din   = d;
      @(posedge clk);
      if (!r) begin
         exp_dout = 8'h00;
      end else if (w) begin
         ref_mem[a]   = d;
         ref_valid[a] = 1'b1;
         exp_dout     = d;
      end else begin
         exp_dout = ref_mem[a];
      end
      #1;
   endtask

   task automatic test_reset();
      drive_edge(1'b0, 1'b0, 8'h00, 8'h00);
      drive_edge(1'b0, 1'b0, 8'h00, 8'h00);
      checks++;
      if (dout !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_dout: got %h expected %h", dout, 8'h00);
      end
   endtask

   task automatic test_write_read();
      drive_edge(1'b1, 1'b1, 8'd3, 8'd11);
      drive_edge(1'b1, 1'b1, 8'd3, 8'd11);
      checks++;
      if (dout !== 8'd11) begin
         errors++;
         $display("[TB] FAIL write_read_3: got %0d expected %0d", dout, 11);
      end
      drive_edge(1'b1, 1'b1, 8'd6, 8'd22);
      drive_edge(1'b1, 1'b1, 8'd6, 8'd22);
      checks++;
      if (dout !== 8'd22) begin
         errors++;
         $display("[TB] FAIL write_read_6: got %0d expected %0d", dout, 22);
      end
   endtask

   task automatic test_read_only();
      drive_edge(1'b1, 1'b0, 8'd3, 8'd33);
      drive_edge(1'b1, 1'b0, 8'd3, 8'd33);
      checks++;
      if (dout !== 8'd11) begin
         errors++;
         $display("[TB] FAIL read_only_3: got %0d expected %0d", dout, 11);
      end
      drive_edge(1'b1, 1'b0, 8'd6, 8'd44);
      checks++;
      if (dout !== 8'd22) begin
         errors++;
         $display("[TB] FAIL read_only_6: got %0d expected %0d", dout, 22);
      end
   endtask

   task automatic test_burst();
      for (int i = 1; i <= 9; i++) begin
         drive_edge(1'b1, 1'b1, 8'(i), 8'(i * 10));
      end
      for (int i = 1; i <= 9; i++) begin
         drive_edge(1'b1, 1'b0, 8'(i), 8'h00);
         checks++;
         if (dout !== 8'(i * 10)) begin
            errors++;
            $display("[TB] FAIL burst_read_%0d: got %0d expected %0d", i, dout, i * 10);
         end
      end
   endtask

   task automatic test_write_first();
      drive_edge(1'b1, 1'b0, 8'd2, 8'h00);
      drive_edge(1'b1, 1'b1, 8'd5, 8'hA5);
      checks++;
      if (dout !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL write_first: got %h expected %h", dout, 8'hA5);
      end
      // Move inputs mid-cycle: the registered output must not follow them.
      @(negedge clk);
      we   = 1'b0;
      addr = 8'd9;
      #2;
      checks++;
      if (dout !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL hold_between_edges: got %h expected %h", dout, 8'hA5);
      end
      addr = 8'd5;
      @(posedge clk);
      exp_dout = ref_mem[5];
      #1;
      checks++;
      if (dout !== 8'hA5 || exp_dout !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL write_first_hold: got %h expected %h", dout, 8'hA5);
      end
   endtask

   task automatic test_reset_retains();
      drive_edge(1'b1, 1'b1, 8'd3, 8'd11);
      drive_edge(1'b0, 1'b1, 8'd3, 8'hFF);
      checks++;
      if (dout !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_clears_dout: got %h expected %h", dout, 8'h00);
      end
      drive_edge(1'b1, 1'b0, 8'd3, 8'h00);
      checks++;
      if (dout !== 8'd11) begin
         errors++;
         $display("[TB] FAIL reset_keeps_mem: got %0d expected %0d", dout, 11);
      end
   endtask

   task automatic test_boundaries();
      drive_edge(1'b1, 1'b1, 8'd1, 8'h11);
      drive_edge(1'b1, 1'b1, 8'd254, 8'hEE);
      drive_edge(1'b1, 1'b1, 8'd0, 8'h5A);
      drive_edge(1'b1, 1'b1, 8'd255, 8'hC3);
      drive_edge(1'b1, 1'b0, 8'd0, 8'h00);
      checks++;
      if (dout !== 8'h5A) begin
         errors++;
         $display("[TB] FAIL bound_addr0: got %h expected %h", dout, 8'h5A);
      end
      drive_edge(1'b1, 1'b0, 8'd255, 8'h00);
      checks++;
      if (dout !== 8'hC3) begin
         errors++;
         $display("[TB] FAIL bound_addr255: got %h expected %h", dout, 8'hC3);
      end
      drive_edge(1'b1, 1'b0, 8'd1, 8'h00);
      checks++;
      if (dout !== 8'h11) begin
         errors++;
         $display("[TB] FAIL bound_addr1: got %h expected %h", dout, 8'h11);
      end
      drive_edge(1'b1, 1'b0, 8'd254, 8'h00);
      checks++;
      if (dout !== 8'hEE) begin
         errors++;
         $display("[TB] FAIL bound_addr254: got %h expected %h", dout, 8'hEE);
      end
   endtask

   task automatic test_random();
      logic       r;
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
      for (int n = 0; n < 400; n++) begin
         r = ($urandom_range(0, 19) != 0);
         w = ($urandom_range(0, 1) == 1);
         a = 8'($urandom_range(0, 255));
         d = 8'($urandom);
         // Never read a word that has not been written yet.
         if (r && !w && !ref_valid[a]) begin
            w = 1'b1;
         end
         drive_edge(r, w, a, d);
         checks++;
         if (dout !== exp_dout) begin
            errors++;
            $display("[TB] FAIL random_%0d: got %h expected %h (rst_n=%b we=%b addr=%0d din=%h)",
                     n, dout, exp_dout, r, w, a, d);
         end
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      exp_dout = 8'h00;
      rst_n    = 1'b0;
      we       = 1'b0;
      addr     = 8'h00;
      din      = 8'h00;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i]   = 8'h00;
         ref_valid[i] = 1'b0;
      end
      test_reset();
      test_write_read();
      test_read_only();
      test_burst();
      test_write_first();
      test_reset_retains();
      test_boundaries();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
